calculation: RTL and testbench

Arithmetic datapath of the vector machine that computes a running sum of squared element differences (squared Euclidean distance). Each cycle it can capture the difference of two vector elements, square the captured difference, and add the squared value into an accumulator. The three stages have independent enables so the vector-machine controller can sequence them one element per cycle. The accumulator is the block's only output.

---
 rtl/calculation.sv | 55 +++++
 tb/tb_calculation.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/calculation.sv
// Squared-distance datapath: D = a-b, SQ = D*D, Sum += SQ, each stage with its own enable.
// Latency: 3 edges from data inputs to a Sum contribution; no backpressure, the enables are trusted as given.
module calculation #(
  parameter int WIDTH = 24
) (
  output logic [WIDTH-1:0] Sum,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic             E_Square,
  input  logic             E_Sum,
  input  logic             Store_D,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_sq;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_sq;
  logic [WIDTH-1:0] w_acc;

  // Only the low WIDTH bits of the product survive, so signedness of D does not matter.
  assign w_diff = data_1 - data_2;
  assign w_sq   = r_d * r_d;
  assign w_acc  = r_sum + r_sq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d <= '0;
    end else if (Store_D) begin
      r_d <= w_diff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sq <= '0;
    end else if (E_Square) begin
      r_sq <= w_sq;
    end
  end

  // Accumulator wraps silently; only reset clears it between vectors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (E_Sum) begin
      r_sum <= w_acc;
    end
  end

  assign Sum = r_sum;

endmodule

// File: tb/tb_calculation.sv
// Directed test of the squared-distance datapath, observing Sum only.
module tb_calculation;

  logic [23:0] Sum;
  logic [23:0] data_1;
  logic [23:0] data_2;
  logic        E_Square;
  logic        E_Sum;
  logic        Store_D;
  logic        clk;
  logic        rst;

  int tests_run = 0;
  int tests_failed = 0;

  calculation #(.WIDTH(24)) dut (
    .Sum      (Sum),
    .data_1   (data_1),
    .data_2   (data_2),
    .E_Square (E_Square),
    .E_Sum    (E_Sum),
    .Store_D  (Store_D),
    .clk      (clk),
    .rst      (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: Sum=%h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [23:0] a, input logic [23:0] b,
                        input logic sd, input logic esq, input logic esum);
    data_1   = a;
    data_2   = b;
    Store_D  = sd;
    E_Square = esq;
    E_Sum    = esum;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset with random data and all enables on.
    rst = 1'b0;
    set_in(24'($urandom), 24'($urandom), 1'b1, 1'b1, 1'b1);
    #1;
    chk("reset_imm", Sum, 24'h0);
    tick();
    chk("reset_hold1", Sum, 24'h0);
    data_1 = 24'($urandom);
    tick();
    chk("reset_hold2", Sum, 24'h0);
    rst = 1'b1;
    tick();
    chk("release_edge1", Sum, 24'h0);
    tick();
    chk("release_edge2", Sum, 24'h0);

    // Single element (1,2) held: D=-1, SQ=1, Sum counts up from edge 3.
    do_reset();
    set_in(24'd1, 24'd2, 1'b1, 1'b1, 1'b1);
    tick(); chk("single_e1", Sum, 24'd0);
    tick(); chk("single_e2", Sum, 24'd0);
    tick(); chk("single_e3", Sum, 24'd1);
    tick(); chk("single_e4", Sum, 24'd2);
    tick(); chk("single_e5", Sum, 24'd3);

    // Pipelined element sequence: SQ 1, 400, 1369.
    do_reset();
    set_in(24'd1, 24'd2, 1'b1, 1'b1, 1'b1);
    tick(); chk("seq_a", Sum, 24'd0);
    set_in(24'd10, 24'd30, 1'b1, 1'b1, 1'b1);
    tick(); chk("seq_b", Sum, 24'd0);
    set_in(24'd40, 24'd77, 1'b1, 1'b1, 1'b1);
    tick(); chk("seq_c", Sum, 24'd1);
    tick(); chk("seq_d", Sum, 24'd401);
    tick(); chk("seq_e", Sum, 24'd1770);

    // E_Sum gated off while data and squares move.
    set_in(24'd5, 24'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk("esum_off1", Sum, 24'd1770);
    set_in(24'd7, 24'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk("esum_off2", Sum, 24'd1770);

    // SQ frozen at 25 while Sum keeps adding it.
    set_in(24'd9, 24'd0, 1'b1, 1'b0, 1'b1);
    tick(); chk("esq_off1", Sum, 24'd1795);
    tick(); chk("esq_off2", Sum, 24'd1820);

    // D frozen at 9 despite new data; SQ becomes 81.
    set_in(24'd100, 24'd0, 1'b0, 1'b1, 1'b0);
    tick(); chk("storeD_off1", Sum, 24'd1820);
    set_in(24'd100, 24'd0, 1'b0, 1'b1, 1'b1);
    tick(); chk("storeD_off2", Sum, 24'd1901);
    tick(); chk("storeD_off3", Sum, 24'd1982);

    // Truncation of 2^24 to 0, then 0xFFF^2 = 0xFFE001 added twice wraps.
    do_reset();
    set_in(24'h001000, 24'd0, 1'b1, 1'b1, 1'b1);
    tick(); chk("wrap_e1", Sum, 24'h0);
    tick(); chk("wrap_e2", Sum, 24'h0);
    tick(); chk("wrap_e3", Sum, 24'h0);
    tick(); chk("wrap_e4", Sum, 24'h0);
    set_in(24'h000FFF, 24'd0, 1'b1, 1'b1, 1'b1);
    tick(); chk("wrap_e5", Sum, 24'h0);
    tick(); chk("wrap_e6", Sum, 24'h0);
    tick(); chk("wrap_e7", Sum, 24'hFFE001);
    tick(); chk("wrap_e8", Sum, 24'hFFC002);

    // Mid-operation reset clears Sum before the next edge.
    rst = 1'b0;
    #1;
    chk("midrst_async", Sum, 24'h0);
    tick(); chk("midrst_hold", Sum, 24'h0);
    rst = 1'b1;
    tick(); chk("midrst_rel1", Sum, 24'h0);
    tick(); chk("midrst_rel2", Sum, 24'h0);
    tick(); chk("midrst_rel3", Sum, 24'hFFE001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
